// File: rtl/multiword_cla_sequencer.sv
// rtl/multiword_cla_sequencer.sv - Multi-cycle W=N*WORDS adder driving one N-bit carry-lookahead adder
// Operands are buffered on accept, summed LSB chunk first with a registered carry, then held until taken.
`timescale 1ns/1ps

module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         cy;
  logic         prod;

  // Every carry is a flat sum of generate terms, independent of the other carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    cy   = 1'b0;
    prod = 1'b1;
    c[0] = c_in;
    for (int i = 0; i < N; i++) begin
      cy   = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cy   = cy | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = cy | (prod & c_in);
    end
    s     = p ^ c[N-1:0];
    c_out = c[N];
  end

endmodule

module multiword_cla_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   s,
  output logic                 c_out,
  output logic                 ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [N-1:0]  a_chunk;
  logic [N-1:0]  b_chunk;
  logic [N-1:0]  sum_chunk;
  logic          chunk_c_out;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IW'(k)) begin
        a_chunk = a_reg[k*N +: N];
        b_chunk = b_reg[k*N +: N];
      end
    end
  end

  cla_adder #(.N(N)) u_cla (
    .a     (a_chunk),
    .b     (b_chunk),
    .c_in  (carry),
    .s     (sum_chunk),
    .c_out (chunk_c_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) s[k*N +: N] <= sum_chunk;
          end
          carry <= chunk_c_out;
          // The top chunk's MSB is the final sign bit of s.
          if (idx == LAST) begin
            c_out     <= chunk_c_out;
            ovf       <= (a_reg[W-1] == b_reg[W-1]) && (sum_chunk[N-1] != a_reg[W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// tb/tb_multiword_cla_sequencer.sv - Scoreboard bench for multiword_cla_sequencer (4x8 and 1x2 instances)
`timescale 1ns/1ps

module tb_multiword_cla_sequencer;

  localparam int WORDS = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        c_in, c_out, ovf;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]  a2, b2, s2;
  logic        c_in2, c_out2, ovf2;

  exp_t        sb[$];
  logic [2:0]  sb2[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multiword_cla_sequencer #(.N(8), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  multiword_cla_sequencer #(.N(2), .WORDS(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .c_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .c_out(c_out2), .ovf(ovf2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input string tag);
    logic [32:0] full;
    exp_t        e;
    full = {1'b0, ta} + {1'b0, tb} + {32'd0, tc};
    e.s  = full[31:0];
    e.c  = full[32];
    e.o  = (ta[31] == tb[31]) && (full[31] != ta[31]);
    check({tag, "_in_ready"}, in_ready, 1);
    sb.push_back(e);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
  endtask

  task automatic accept_and_wait(input string tag);
    int lat;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c_in = ~c_in;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, WORDS);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_busy"}, in_ready, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_s"}, s, e.s);
      check({tag, "_c_out"}, c_out, e.c);
      check({tag, "_ovf"}, ovf, e.o);
    end
    out_ready = 1'b1;
    step();
    check({tag, "_drain_valid"}, out_valid, 0);
    check({tag, "_drain_ready"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; c_in2 = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready2", in_ready2, 1);

    start_op(32'h000000FF, 32'h00000001, 1'b0, "t1");
    accept_and_wait("t1");
    collect("t1");

    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "t2");
    accept_and_wait("t2");
    collect("t2");

    start_op(32'h12345678, 32'h11111111, 1'b1, "t3b");
    accept_and_wait("t3b");
    check("t3b_literal", s, 32'h2345678A);
    collect("t3b");

    // Backpressure with a competing request held on the input side
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "t3");
    out_ready = 1'b0;
    accept_and_wait("t3");
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_s", s, 32'h80000000);
      check("bp_ovf", ovf, 1);
    end
    collect("t3");
    start_op(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, "t4");
    accept_and_wait("t4");
    collect("t4");

    // Abort in the second RUN cycle
    start_op(32'hDEADBEEF, 32'h01010101, 1'b0, "t5");
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_s", s, 0);
    check("abort_c_out", c_out, 0);
    start_op(32'h00000003, 32'h00000005, 1'b0, "t5b");
    accept_and_wait("t5b");
    collect("t5b");

    // Single-chunk instance: exhaustive 2-bit sweep
    for (int aa = 0; aa < 4; aa++) begin
      for (int bb = 0; bb < 4; bb++) begin
        for (int cc = 0; cc < 2; cc++) begin
          logic [2:0] e2;
          check("w1_in_ready", in_ready2, 1);
          a2 = 2'(aa); b2 = 2'(bb); c_in2 = cc[0]; in_valid2 = 1'b1;
          sb2.push_back(3'(aa + bb + cc));
          step();
          in_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
          check("w1_run_valid", out_valid2, 0);
          step();
          check("w1_out_valid", out_valid2, 1);
          e2 = sb2.pop_front();
          check("w1_sum", {c_out2, s2}, e2);
          step();
          check("w1_drain", out_valid2, 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
